// File: rtl/morty_bus_pkg.sv
// Shared encodings for the morty memory-bus arbiter: FSM states, master
// indices and the default bus timeout.
package morty_bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GNT_IF  = 2'b01;
  localparam logic [1:0] ST_GNT_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GNT_IF  = ST_GNT_IF,
    GNT_MEM = ST_GNT_MEM
  } bus_state_e;

  localparam logic MST_IF  = 1'b0;
  localparam logic MST_MEM = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/morty_bus_timeout.sv
// Clear/enable saturating cycle counter; tc_o flags the last cycle before a
// granted transfer is declared hung. TIMEOUT_CYCLES = 0 disables tc_o.
module morty_bus_timeout
  import morty_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_TC  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_TC);

endmodule

// File: rtl/morty_wb_arbiter.sv
// Two-master (IF fetch, MEM load/store) to one-slave classic Wishbone arbiter.
// One transfer per grant, with an IDLE cycle between grants and a bus timeout.
module morty_wb_arbiter
  import morty_bus_pkg::*;
#(
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_addr_i,
  input  logic        if_cyc_i,
  input  logic        if_stb_i,
  output logic [31:0] if_dat_o,
  output logic        if_ack_o,
  output logic        if_err_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_dat_i,
  input  logic [3:0]  mem_sel_i,
  input  logic        mem_we_i,
  input  logic        mem_cyc_i,
  input  logic        mem_stb_i,
  output logic [31:0] mem_dat_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic [31:0] wbs_addr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i
);

  bus_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       req_if, req_mem, gnt_if, gnt_mem;
  logic       slv_resp, tmo_tc, tmo_fire;

  assign req_if   = if_cyc_i & if_stb_i;
  assign req_mem  = mem_cyc_i & mem_stb_i;
  assign gnt_if   = (state_q == GNT_IF);
  assign gnt_mem  = (state_q == GNT_MEM);
  assign slv_resp = wbs_ack_i | wbs_err_i;
  // A real slave response in the terminal cycle beats the synthetic error.
  assign tmo_fire = (gnt_if | gnt_mem) & tmo_tc & ~slv_resp;

  morty_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (state_q == IDLE),
    .en_i  ((gnt_if | gnt_mem) & ~slv_resp),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req_if && req_mem) begin
          state_d = (RR_EN && (last_gnt_q == MST_MEM)) ? GNT_IF : GNT_MEM;
        end else if (req_if) begin
          state_d = GNT_IF;
        end else if (req_mem) begin
          state_d = GNT_MEM;
        end
        if (state_d == GNT_IF)  last_gnt_d = MST_IF;
        if (state_d == GNT_MEM) last_gnt_d = MST_MEM;
      end
      GNT_IF: begin
        if (slv_resp || !if_cyc_i || tmo_fire) state_d = IDLE;
      end
      GNT_MEM: begin
        if (slv_resp || !mem_cyc_i || tmo_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= MST_MEM;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // The fetch port is read-only, so its write data and selects are fixed.
  always_comb begin
    wbs_addr_o = '0;
    wbs_dat_o  = '0;
    wbs_sel_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    if (gnt_if) begin
      wbs_addr_o = if_addr_i;
      wbs_sel_o  = 4'hF;
      wbs_cyc_o  = if_cyc_i & ~tmo_fire;
      wbs_stb_o  = if_stb_i & ~tmo_fire;
    end else if (gnt_mem) begin
      wbs_addr_o = mem_addr_i;
      wbs_dat_o  = mem_dat_i;
      wbs_sel_o  = mem_sel_i;
      wbs_we_o   = mem_we_i;
      wbs_cyc_o  = mem_cyc_i & ~tmo_fire;
      wbs_stb_o  = mem_stb_i & ~tmo_fire;
    end
  end

  assign if_dat_o  = wbs_dat_i;
  assign mem_dat_o = wbs_dat_i;
  assign if_ack_o  = gnt_if & wbs_ack_i & ~wbs_err_i;
  assign if_err_o  = gnt_if & (wbs_err_i | tmo_fire);
  assign mem_ack_o = gnt_mem & wbs_ack_i & ~wbs_err_i;
  assign mem_err_o = gnt_mem & (wbs_err_i | tmo_fire);

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// Bench for morty_wb_arbiter: a reactive slave pops an expected-transfer queue
// on every ack; directed phases cover arbitration, timeout and reset.
module tb_morty_wb_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } xfer_t;

  logic        clk_i, rst_ni;
  logic [31:0] if_addr_i, mem_addr_i, mem_dat_i, wbs_dat_i;
  logic [3:0]  mem_sel_i;
  logic        if_cyc_i, if_stb_i, mem_we_i, mem_cyc_i, mem_stb_i;
  logic        sl_ack, man_ack, man_err;
  logic        wbs_ack_i, wbs_err_i;

  logic [31:0] if_dat_o, mem_dat_o, wbs_addr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        if_ack_o, if_err_o, mem_ack_o, mem_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o;

  logic [31:0] d1_if_dat_o, d1_mem_dat_o, d1_wbs_addr_o, d1_wbs_dat_o;
  logic [3:0]  d1_wbs_sel_o;
  logic        d1_if_ack_o, d1_if_err_o, d1_mem_ack_o, d1_mem_err_o;
  logic        d1_wbs_cyc_o, d1_wbs_stb_o, d1_wbs_we_o;

  assign wbs_ack_i = sl_ack | man_ack;
  assign wbs_err_i = man_err;

  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    slave_on;
  int    slave_lat;

  morty_wb_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(4)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_addr_i(if_addr_i), .if_cyc_i(if_cyc_i), .if_stb_i(if_stb_i),
    .if_dat_o(if_dat_o), .if_ack_o(if_ack_o), .if_err_o(if_err_o),
    .mem_addr_i(mem_addr_i), .mem_dat_i(mem_dat_i), .mem_sel_i(mem_sel_i),
    .mem_we_i(mem_we_i), .mem_cyc_i(mem_cyc_i), .mem_stb_i(mem_stb_i),
    .mem_dat_o(mem_dat_o), .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
    .wbs_addr_o(wbs_addr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  morty_wb_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(4)) u_dut_fp (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_addr_i(if_addr_i), .if_cyc_i(if_cyc_i), .if_stb_i(if_stb_i),
    .if_dat_o(d1_if_dat_o), .if_ack_o(d1_if_ack_o), .if_err_o(d1_if_err_o),
    .mem_addr_i(mem_addr_i), .mem_dat_i(mem_dat_i), .mem_sel_i(mem_sel_i),
    .mem_we_i(mem_we_i), .mem_cyc_i(mem_cyc_i), .mem_stb_i(mem_stb_i),
    .mem_dat_o(d1_mem_dat_o), .mem_ack_o(d1_mem_ack_o), .mem_err_o(d1_mem_err_o),
    .wbs_addr_o(d1_wbs_addr_o), .wbs_dat_o(d1_wbs_dat_o), .wbs_sel_o(d1_wbs_sel_o),
    .wbs_cyc_o(d1_wbs_cyc_o), .wbs_stb_o(d1_wbs_stb_o), .wbs_we_o(d1_wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic push_if(input logic [31:0] a);
    xfer_t e;
    e = '{addr: a, we: 1'b0, sel: 4'hF, dat: 32'h0};
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w);
    xfer_t e;
    e = '{addr: a, we: w, sel: s, dat: d};
    exp_q.push_back(e);
  endtask

  // Slave: acks slave_lat cycles after first seeing stb and checks the bus
  // fields against the next expected transfer.
  initial begin
    int    cnt;
    xfer_t e;
    cnt = 0;
    sl_ack = 1'b0;
    wbs_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      sl_ack = 1'b0;
      if (slave_on && wbs_cyc_o && wbs_stb_o) begin
        if (cnt == slave_lat) begin
          cnt = 0;
          wbs_dat_i = rdata(wbs_addr_o);
          sl_ack = 1'b1;
          if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_addr", wbs_addr_o, e.addr);
            chk("sb_we", 32'(wbs_we_o), 32'(e.we));
            chk("sb_sel", 32'(wbs_sel_o), 32'(e.sel));
            chk("sb_wdat", wbs_dat_o, e.dat);
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic reset_dut();
    rst_ni = 1'b0;
    if_cyc_i = 1'b0; if_stb_i = 1'b0;
    mem_cyc_i = 1'b0; mem_stb_i = 1'b0; mem_we_i = 1'b0;
    man_ack = 1'b0; man_err = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Called just after a posedge; returns just after a later posedge.
  task automatic if_xfer(input logic [31:0] a, input bit keep);
    int t;
    if_addr_i = a; if_cyc_i = 1'b1; if_stb_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!(if_ack_o || if_err_o) && t < 64);
    if (!(if_ack_o || if_err_o)) begin
      chk("if_no_resp", 32'(if_ack_o | if_err_o), 32'd1);
    end else begin
      chk("if_rdata", if_dat_o, rdata(a));
      chk("if_err", 32'(if_err_o), 32'd0);
      chk("if_excl", 32'(mem_ack_o | mem_err_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    if (!keep) begin
      if_cyc_i = 1'b0; if_stb_i = 1'b0;
    end
  endtask

  task automatic mem_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input bit keep);
    int t;
    mem_addr_i = a; mem_dat_i = d; mem_sel_i = s; mem_we_i = w;
    mem_cyc_i = 1'b1; mem_stb_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!(mem_ack_o || mem_err_o) && t < 64);
    if (!(mem_ack_o || mem_err_o)) begin
      chk("mem_no_resp", 32'(mem_ack_o | mem_err_o), 32'd1);
    end else begin
      if (!w) chk("mem_rdata", mem_dat_o, rdata(a));
      chk("mem_err", 32'(mem_err_o), 32'd0);
      chk("mem_excl", 32'(if_ack_o | if_err_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    if (!keep) begin
      mem_cyc_i = 1'b0; mem_stb_i = 1'b0; mem_we_i = 1'b0;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    if_addr_i = '0; if_cyc_i = 1'b0; if_stb_i = 1'b0;
    mem_addr_i = '0; mem_dat_i = '0; mem_sel_i = '0;
    mem_we_i = 1'b0; mem_cyc_i = 1'b0; mem_stb_i = 1'b0;
    man_ack = 1'b0; man_err = 1'b0;
    slave_on = 1'b0; slave_lat = 2;

    // Reset state
    @(negedge clk_i);
    chk("rst_cyc", 32'(wbs_cyc_o), 0);
    chk("rst_stb", 32'(wbs_stb_o), 0);
    chk("rst_we", 32'(wbs_we_o), 0);
    chk("rst_sel", 32'(wbs_sel_o), 0);
    chk("rst_addr", wbs_addr_o, 0);
    chk("rst_wdat", wbs_dat_o, 0);
    chk("rst_resp", {28'd0, if_ack_o, if_err_o, mem_ack_o, mem_err_o}, 0);
    chk("rst_ifdat", if_dat_o, 0);
    chk("rst_fp_stb", 32'(d1_wbs_stb_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single IF read of 0x10
    slave_on = 1'b1;
    push_if(32'h10);
    @(posedge clk_i); #1;
    fork
      if_xfer(32'h10, 1'b0);
      begin
        @(negedge clk_i);
        chk("arb_lat_stb", 32'(wbs_stb_o), 0);
      end
    join
    @(negedge clk_i);
    chk("idle_after_if", 32'(wbs_cyc_o), 0);
    chk("sb_drain_a", 32'(exp_q.size()), 0);

    // Round-robin: both masters stream 4 back-to-back requests
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      push_if(32'h1000 + 32'(4 * i));
      push_mem(32'h2000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1);
    end
    @(posedge clk_i); #1;
    fork
      for (int i = 0; i < 4; i++) if_xfer(32'h1000 + 32'(4 * i), i < 3);
      for (int j = 0; j < 4; j++)
        mem_xfer(32'h2000 + 32'(4 * j), 32'hA000_0000 + 32'(j), 4'hF, 1'b1, j < 3);
    join
    chk("sb_drain_rr", 32'(exp_q.size()), 0);

    // Fixed priority vs round-robin on simultaneous requests
    slave_on = 1'b0;
    reset_dut();
    @(posedge clk_i); #1;
    if_addr_i = 32'h40; if_cyc_i = 1'b1; if_stb_i = 1'b1;
    mem_addr_i = 32'h80; mem_dat_i = 32'h55; mem_sel_i = 4'hF; mem_we_i = 1'b1;
    mem_cyc_i = 1'b1; mem_stb_i = 1'b1;
    @(negedge clk_i);
    chk("both_idle_stb", 32'(wbs_stb_o), 0);
    chk("both_idle_fp_stb", 32'(d1_wbs_stb_o), 0);
    @(negedge clk_i);
    chk("rr_first_if", wbs_addr_o, 32'h40);
    chk("rr_first_we", 32'(wbs_we_o), 0);
    chk("fp_first_mem", d1_wbs_addr_o, 32'h80);
    chk("fp_first_we", 32'(d1_wbs_we_o), 1);
    man_ack = 1'b1;
    @(posedge clk_i); #1;
    man_ack = 1'b0;
    @(negedge clk_i);
    chk("gap_idle_stb", 32'(wbs_stb_o), 0);
    @(negedge clk_i);
    chk("rr_second_mem", wbs_addr_o, 32'h80);
    chk("fp_second_mem", d1_wbs_addr_o, 32'h80);
    man_ack = 1'b1;
    @(posedge clk_i); #1;
    man_ack = 1'b0;
    if_cyc_i = 1'b0; if_stb_i = 1'b0;
    mem_cyc_i = 1'b0; mem_stb_i = 1'b0; mem_we_i = 1'b0;

    // MEM write with IF request arriving while MEM holds the bus
    slave_on = 1'b1;
    reset_dut();
    push_mem(32'h100, 32'h1234_5678, 4'b0011, 1'b1);
    push_if(32'h300);
    fork
      begin
        @(posedge clk_i); #1;
        mem_xfer(32'h100, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
      end
      begin
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        if_xfer(32'h300, 1'b0);
      end
    join
    chk("sb_drain_w", 32'(exp_q.size()), 0);

    // Timeout on a silent slave, then ack winning at the terminal count
    slave_on = 1'b0;
    reset_dut();
    @(posedge clk_i); #1;
    if_addr_i = 32'h200; if_cyc_i = 1'b1; if_stb_i = 1'b1;
    @(negedge clk_i);
    chk("tmo_idle_stb", 32'(wbs_stb_o), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      if (k < 4) begin
        chk("tmo_wait_stb", 32'(wbs_stb_o), 1);
        chk("tmo_wait_err", 32'(if_err_o), 0);
      end else begin
        chk("tmo_err", 32'(if_err_o), 1);
        chk("tmo_ack", 32'(if_ack_o), 0);
        chk("tmo_cyc_drop", 32'(wbs_cyc_o), 0);
        chk("tmo_stb_drop", 32'(wbs_stb_o), 0);
        chk("tmo_mem_err", 32'(mem_err_o), 0);
      end
    end
    @(negedge clk_i);
    chk("tmo_after_err", 32'(if_err_o), 0);
    chk("tmo_after_stb", 32'(wbs_stb_o), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      if (k < 4) begin
        chk("regnt_stb", 32'(wbs_stb_o), 1);
        chk("regnt_err", 32'(if_err_o), 0);
      end else begin
        man_ack = 1'b1;
        #1;
        chk("tc_ack_wins", 32'(if_ack_o), 1);
        chk("tc_ack_noerr", 32'(if_err_o), 0);
        chk("tc_ack_cyc", 32'(wbs_cyc_o), 1);
      end
    end
    @(posedge clk_i); #1;
    man_ack = 1'b0;
    if_cyc_i = 1'b0; if_stb_i = 1'b0;
    @(negedge clk_i);
    chk("tmo_end_stb", 32'(wbs_stb_o), 0);

    // Slave ack and err together
    reset_dut();
    @(posedge clk_i); #1;
    mem_addr_i = 32'h400; mem_we_i = 1'b0; mem_sel_i = 4'hF;
    mem_cyc_i = 1'b1; mem_stb_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    man_ack = 1'b1; man_err = 1'b1;
    #1;
    chk("ackerr_err", 32'(mem_err_o), 1);
    chk("ackerr_ack", 32'(mem_ack_o), 0);
    chk("ackerr_if", 32'(if_ack_o | if_err_o), 0);
    @(posedge clk_i); #1;
    man_ack = 1'b0; man_err = 1'b0;
    mem_cyc_i = 1'b0; mem_stb_i = 1'b0;

    // Asynchronous reset in the middle of a MEM grant
    reset_dut();
    @(posedge clk_i); #1;
    mem_addr_i = 32'h500; mem_dat_i = 32'h77; mem_we_i = 1'b1;
    mem_cyc_i = 1'b1; mem_stb_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_stb", 32'(wbs_stb_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wbs_cyc_o), 0);
    chk("async_rst_stb", 32'(wbs_stb_o), 0);
    mem_cyc_i = 1'b0; mem_stb_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    if_addr_i = 32'h600; if_cyc_i = 1'b1; if_stb_i = 1'b1;
    mem_addr_i = 32'h700; mem_cyc_i = 1'b1; mem_stb_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("post_rst_if_first", wbs_addr_o, 32'h600);
    chk("post_rst_fp_mem", d1_wbs_addr_o, 32'h700);
    man_ack = 1'b1;
    @(posedge clk_i); #1;
    man_ack = 1'b0;
    if_cyc_i = 1'b0; if_stb_i = 1'b0;
    mem_cyc_i = 1'b0; mem_stb_i = 1'b0;
    @(negedge clk_i);

    chk("sb_left", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morty_wb_arbiter.md
Name: morty_wb_arbiter

Overview:
Two-master/one-slave Wishbone (classic, single-transfer) arbiter sharing the processor's single memory bus between the IF stage fetch port (read-only) and the MEM stage load/store port. Grant is held for one transfer, from grant until ack/err/abort. A bus timeout converts a hung slave into an err to the owning master, so the pipeline takes an access-fault trap instead of deadlocking.

Parameters:
RR_EN, 1, 1 = round-robin between IF and MEM; 0 = fixed priority, MEM wins.
TIMEOUT_CYCLES, 255, granted cycles without ack/err before a synthetic err is raised; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
if_addr_i  in  32  IF master address
if_cyc_i  in  1  IF cycle
if_stb_i  in  1  IF strobe
if_dat_o  out  32  read data to IF
if_ack_o  out  1  ack to IF
if_err_o  out  1  err to IF
mem_addr_i  in  32  MEM master address
mem_dat_i  in  32  MEM write data
mem_sel_i  in  4  MEM byte selects
mem_we_i  in  1  MEM write enable
mem_cyc_i  in  1  MEM cycle
mem_stb_i  in  1  MEM strobe
mem_dat_o  out  32  read data to MEM
mem_ack_o  out  1  ack to MEM
mem_err_o  out  1  err to MEM
wbs_addr_o / wbs_dat_o / wbs_sel_o  out  32/32/4  slave address, write data, selects
wbs_cyc_o / wbs_stb_o / wbs_we_o  out  1 each  slave cycle, strobe, write enable
wbs_dat_i  in  32  slave read data
wbs_ack_i / wbs_err_i  in  1 each  slave ack, err

Behaviour:
- Request: req_if = if_cyc_i & if_stb_i; req_mem = mem_cyc_i & mem_stb_i.
- States: IDLE, GNT_IF, GNT_MEM. Reset (async, any time, including mid-transfer) forces IDLE, last_gnt = MEM, timeout count = 0.
- Reset values: all outputs 0. IF/MEM data outputs carry wbs_dat_i unconditionally; this is a don't-care without ack.
- IDLE transitions:
  - Single request: go to its GNT state.
  - Both requesting, RR_EN=1: grant the master that is not last_gnt, so IF wins first after reset.
  - Both requesting, RR_EN=0: MEM wins.
  - No request: stay in IDLE.
  - Arbitration latency is 1 cycle. The slave never sees stb in IDLE.
- GNT_x:
  - Slave outputs are combinationally muxed from master x.
  - For IF: wbs_we_o = 0, wbs_sel_o = 4'hF, wbs_dat_o = 0.
  - wbs_cyc_o/wbs_stb_o follow the master's cyc/stb.
  - last_gnt <= x on entry.
- Response routing: wbs_ack_i/wbs_err_i go combinationally to the granted master only; the non-granted master sees ack = err = 0. If ack and err are both high, err is forwarded and ack is masked.
- Release: on a cycle with ack, err, or master cyc low (abort), next state = IDLE. The master's own cycle ends the same cycle, so there is no back-to-back grant without an IDLE cycle. Minimum transfer: grant cycle + ack cycle, plus the IDLE cycle.
- Timeout:
  - Counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to GNT and increments each GNT cycle without ack/err.
  - When count == TIMEOUT_CYCLES-1 and no ack/err arrives: assert x_err_o for that cycle, drive wbs_cyc_o = wbs_stb_o = 0 that cycle, next state = IDLE.
  - A slave ack arriving in the same cycle as the timeout wins; it is a normal completion.
  - The counter saturates and never wraps.
- A request arriving while the other master is granted waits, with no ack/err, until the next IDLE. No starvation with RR_EN=1: a waiting master gets the next grant.

Decomposition:
- Package morty_bus_pkg: state encoding localparams (IDLE = 2'b00, GNT_IF = 2'b01, GNT_MEM = 2'b10), master indices MST_IF = 0 and MST_MEM = 1, and the default timeout constant.
- One sub-module, morty_bus_timeout: a clear/enable saturating counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then IF read of 0x0000_0010, slave acks 2 cycles after stb with 0xDEAD_BEEF -> wbs_addr_o = 0x10, wbs_we_o = 0, wbs_sel_o = F; if_ack_o = 1 with if_dat_o = 0xDEADBEEF; mem_ack_o stays 0; state returns to IDLE.
- IF and MEM request in the same cycle, RR_EN=1, 4 consecutive transfers each side -> grant order IF, MEM, IF, MEM, ...; with RR_EN=0 -> MEM first.
- MEM write to 0x100, data 0x1234_5678, sel 4'b0011 -> slave sees exactly those values with we = 1; IF request held pending until IDLE, then granted.
- TIMEOUT_CYCLES=4, slave never responds -> if_err_o pulses 1 cycle on the 4th granted cycle, wbs_cyc_o drops, next request granted after IDLE.
- Slave asserts ack and err together -> granted master sees err = 1, ack = 0.
- rst_ni low mid-transfer (GNT_MEM, no ack yet) -> wbs_cyc_o/stb_o = 0 immediately, without waiting for a clock; after release, first simultaneous request grants IF.
